risac_led_pio: RTL and testbench
================================

RISAC_LED_PIO -- requirements
Module: risac_led_pio

Interface
REQ-001 Parameter LED_WIDTH, default 10: number of LED outputs.
REQ-002 Parameter BLINK_DIV, default 25000000: clock50 cycles per blink phase (0.5 s at 50 MHz); legal range 2..2^26-1.
REQ-003 clock50  input  1  system clock; all state rises on clock50.
REQ-004 reset_n  input  1  asynchronous active-low reset (assert asynchronously, release synchronous to clock50 upstream).
REQ-005 avs_address  input  2  word address of register.
REQ-006 avs_write  input  1  write strobe, one beat per cycle.
REQ-007 avs_writedata  input  32  write data.
REQ-008 avs_read  input  1  read strobe.
REQ-009 avs_readdata  output  32  read data, valid with avs_readdatavalid.
REQ-010 avs_readdatavalid  output  1  one-cycle pulse marking avs_readdata valid.
REQ-011 ledr  output  LED_WIDTH  registered LED drive, to SoC top port.

Function
REQ-012 Register map: 0 DATA (rw), 1 SET (wo, write-1-set DATA), 2 CLR (wo, write-1-clear DATA), 3 BLINK (rw mask).
REQ-013 Only writedata[LED_WIDTH-1:0] used; readdata upper bits SHALL read 0.
REQ-014 Writes take effect at the clock edge they are sampled; DATA/BLINK visible on next read.
REQ-015 Read latency fixed at 1: readdatavalid high exactly the cycle after avs_read sampled, readdata held until next read.
REQ-016 Reads of SET/CLR SHALL return current DATA.
REQ-017 Back-to-back reads every cycle SHALL each produce one readdatavalid pulse, in order.
REQ-018 Simultaneous avs_read and avs_write: write performed; read returns pre-write register value.
REQ-019 Blink counter counts 0..BLINK_DIV-1, wraps to 0 and toggles phase on wrap.
REQ-020 ledr = DATA & ~(BLINK & {LED_WIDTH{phase}}), registered: one cycle after DATA/BLINK/phase change.
REQ-021 Writing BLINK SHALL NOT reset counter or phase.
REQ-022 SET and CLR with overlapping bits in consecutive cycles apply in order; no bits lost.

Reset
REQ-023 reset_n low: DATA=0, BLINK=0, counter=0, phase=0, ledr=0, readdatavalid=0, readdata=0.
REQ-024 Reset mid-read: pending readdatavalid SHALL be dropped.
REQ-025 First access accepted on first clock50 edge after reset_n high.

Configuration
REQ-026 Macro RISAC_LED_BLINK_EN: defined -> BLINK register, counter and phase present as above.
REQ-027 Undefined -> no counter logic; BLINK reads 0, writes ignored; ledr = DATA registered.

Structure
REQ-028 Package risac_soc_pkg holds LED register offset constants (DATA/SET/CLR/BLINK) and default LED_WIDTH.
REQ-029 Blink prescaler SHALL be sub-module risac_led_blink_tick (counter + phase, parameter BLINK_DIV), instantiated only under RISAC_LED_BLINK_EN.

Verification
REQ-030 Reset, write DATA=0x2A5 -> read DATA returns 0x2A5 one cycle after read; ledr=0x2A5 one cycle after write.
REQ-031 DATA=0x00F, write SET=0x300, then CLR=0x003 -> DATA=0x30C, ledr=0x30C.
REQ-032 BLINK_DIV=4, DATA=0x3FF, BLINK=0x001 -> ledr alternates 0x3FF/0x3FE every 4 cycles.
REQ-033 Reads on 3 consecutive cycles of addr 0,3,1 -> 3 readdatavalid pulses, data DATA, BLINK, DATA.
REQ-034 Read and write DATA=0x155 same cycle with DATA=0x0AA -> readdata 0x0AA, then DATA=0x155.
REQ-035 reset_n pulsed low mid-blink with read pending -> all outputs 0, no readdatavalid, counter restarts.

Source files
------------

// File: rtl/risac_soc_pkg.sv
// Shared SoC constants: LED PIO register word offsets and the default LED count.
package risac_soc_pkg;

    localparam int LED_WIDTH_DEFAULT = 10;

    localparam logic [1:0] LED_REG_DATA  = 2'd0;
    localparam logic [1:0] LED_REG_SET   = 2'd1;
    localparam logic [1:0] LED_REG_CLR   = 2'd2;
    localparam logic [1:0] LED_REG_BLINK = 2'd3;

endpackage

// File: rtl/risac_led_blink_tick.sv
// Blink prescaler: counts 0..BLINK_DIV-1 on clock50 and toggles phase on every wrap.
module risac_led_blink_tick #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clock50,
    input  logic reset_n,
    output logic phase
);

    // 26 bits covers the full legal BLINK_DIV range.
    localparam logic [25:0] CNT_LAST = 26'(BLINK_DIV - 1);

    logic [25:0] cnt;

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 26'd1;
        end
    end

endmodule

// File: rtl/risac_led_pio.sv
// LED PIO slave: DATA/SET/CLR/BLINK registers driving a registered ledr port.
// Blink hardware is built only when RISAC_LED_BLINK_EN is defined; otherwise ledr follows DATA.
module risac_led_pio
    import risac_soc_pkg::*;
#(
    parameter int LED_WIDTH = LED_WIDTH_DEFAULT,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                 clock50,
    input  logic                 reset_n,
    input  logic [1:0]           avs_address,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic [LED_WIDTH-1:0] ledr
);

    // Bus handshake: the slave never stalls. A write beat is committed on the edge
    // it is sampled; a read sampled on edge N returns data with a one-cycle
    // readdatavalid pulse after edge N, using register values from before any
    // write in the same beat. readdata holds its value until the next read.

    logic [LED_WIDTH-1:0] data_q;
    logic [LED_WIDTH-1:0] wdata;
    logic [LED_WIDTH-1:0] blink_rd;
    logic [LED_WIDTH-1:0] led_next;
    logic [LED_WIDTH-1:0] rd_mux;
    logic                 unused_wdata;

    assign wdata        = avs_writedata[LED_WIDTH-1:0];
    assign unused_wdata = ^avs_writedata[31:LED_WIDTH];

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (avs_write) begin
            case (avs_address)
                LED_REG_DATA: data_q <= wdata;
                LED_REG_SET:  data_q <= data_q | wdata;
                LED_REG_CLR:  data_q <= data_q & ~wdata;
                default:      data_q <= data_q;
            endcase
        end
    end

`ifdef RISAC_LED_BLINK_EN
    logic [LED_WIDTH-1:0] blink_q;
    logic                 phase;

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= '0;
        end else if (avs_write && (avs_address == LED_REG_BLINK)) begin
            blink_q <= wdata;
        end
    end

    risac_led_blink_tick #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_tick (
        .clock50 (clock50),
        .reset_n (reset_n),
        .phase   (phase)
    );

    assign blink_rd = blink_q;
    assign led_next = data_q & ~(blink_q & {LED_WIDTH{phase}});
`else
    localparam int unused_blink_div = BLINK_DIV;

    assign blink_rd = '0;
    assign led_next = data_q;
`endif

    // SET and CLR are write-only strobes; reading them reports DATA.
    always_comb begin
        rd_mux = data_q;
        if (avs_address == LED_REG_BLINK) begin
            rd_mux = blink_rd;
        end
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            ledr              <= '0;
        end else begin
            avs_readdatavalid <= avs_read;
            ledr              <= led_next;
            if (avs_read) begin
                avs_readdata <= 32'(rd_mux);
            end
        end
    end

endmodule

// File: tb/tb_risac_led_pio.sv
// Self-checking bench for risac_led_pio: register model, read scoreboard, LED and blink timing.
// Blink expectations follow RISAC_LED_BLINK_EN exactly as the design build does.
module tb_risac_led_pio;

    localparam int LW = 10;

    logic          clock50 = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    avs_address = '0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic          avs_read = 1'b0;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic [LW-1:0] ledr;

    logic [31:0]   exp_q[$];
    logic [LW-1:0] m_data  = '0;
    logic [LW-1:0] m_blink = '0;
    int            n_checks = 0;
    int            n_errors = 0;

    risac_led_pio #(
        .LED_WIDTH (LW),
        .BLINK_DIV (4)
    ) dut (
        .clock50           (clock50),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .ledr              (ledr)
    );

    // clock / reset
    always #5 clock50 = ~clock50;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        return (a == 2'd3) ? 32'(m_blink) : 32'(m_data);
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: m_data = d[LW-1:0];
            2'd1: m_data = m_data | d[LW-1:0];
            2'd2: m_data = m_data & ~d[LW-1:0];
            default: begin
`ifdef RISAC_LED_BLINK_EN
                m_blink = d[LW-1:0];
`endif
            end
        endcase
    endfunction

    // driver tasks: each drives one bus beat and returns 1 ns after its edge
    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        model_write(a, d);
        @(posedge clock50); #1;
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a);
        avs_address = a; avs_read = 1'b1;
        exp_q.push_back(model_read(a));
        @(posedge clock50); #1;
        avs_read = 1'b0;
    endtask

    task automatic do_rw(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_read = 1'b1; avs_write = 1'b1;
        exp_q.push_back(model_read(a));
        model_write(a, d);
        @(posedge clock50); #1;
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock50); #1;
        end
    endtask

    // scoreboard: every readdatavalid pulse consumes one expected read
    always @(negedge clock50) begin
        if (avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                chk("rdv_unexpected", {31'b0, avs_readdatavalid}, 32'd0);
            end else begin
                chk("readdata", avs_readdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock50);
        #1;
        chk("rst_ledr", 32'(ledr), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_rdv", {31'b0, avs_readdatavalid}, 32'd0);
        @(negedge clock50);
        reset_n = 1'b1;

        // first access on the first edge after release; ledr lags DATA by one cycle
        do_write(2'd0, 32'h2A5);
        chk("ledr_lag", 32'(ledr), 32'd0);
        do_read(2'd0);
        chk("ledr_data", 32'(ledr), 32'h2A5);

        // SET then CLR
        do_write(2'd0, 32'h00F);
        do_write(2'd1, 32'h300);
        do_write(2'd2, 32'h003);
        do_read(2'd0);
        chk("ledr_setclr", 32'(ledr), 32'h30C);
        do_read(2'd1);
        do_read(2'd2);

        // overlapping SET/CLR/SET on consecutive cycles
        do_write(2'd1, 32'h0F0);
        do_write(2'd2, 32'h030);
        do_write(2'd1, 32'h010);
        do_read(2'd0);
        chk("model_overlap", 32'(m_data), 32'h3DC);

        // only low LED_WIDTH bits stored; readdata upper bits are zero
        do_write(2'd0, 32'hFFFF_FC55);
        do_read(2'd0);

        // simultaneous read and write returns the old value
        do_write(2'd0, 32'h0AA);
        do_rw(2'd0, 32'h155);
        do_read(2'd0);
        chk("ledr_rw", 32'(ledr), 32'h155);

        // random SET/CLR traffic against the model
        for (int i = 0; i < 6; i++) begin
            do_write(2'($urandom_range(1, 2)), 32'($urandom_range(0, 1023)));
            do_read(2'($urandom_range(0, 2)));
        end

        // back-to-back reads of DATA, BLINK, SET
        do_write(2'd3, 32'h001);
        do_read(2'd0);
        do_read(2'd3);
        do_read(2'd1);
        idle(2);

        // reset while a readdatavalid pulse is outstanding
        do_write(2'd0, 32'h3FF);
        avs_address = 2'd0; avs_read = 1'b1;
        @(posedge clock50); #1;
        avs_read = 1'b0;
        reset_n = 1'b0;
        m_data = '0; m_blink = '0;
        #1;
        chk("mid_rst_rdv", {31'b0, avs_readdatavalid}, 32'd0);
        chk("mid_rst_readdata", avs_readdata, 32'd0);
        chk("mid_rst_ledr", 32'(ledr), 32'd0);
        repeat (2) @(posedge clock50);
        @(negedge clock50);
        reset_n = 1'b1;

        // counter restarts at release: phase flips on the 4th edge, ledr one edge later
        do_write(2'd0, 32'h3FF);
        do_write(2'd3, 32'h001);
        for (int i = 2; i <= 9; i++) begin
            logic [31:0] exp_led;
            @(posedge clock50); #1;
            exp_led = 32'h3FF;
`ifdef RISAC_LED_BLINK_EN
            if (i >= 4 && i <= 7) exp_led = 32'h3FE;
`endif
            chk($sformatf("blink_e%0d", i), 32'(ledr), exp_led);
        end
        do_read(2'd3);
        do_read(2'd0);

        idle(3);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
